// File: rtl/or_gate_checker.sv
// or_gate_checker: drives stimulus to an enable-gated pass-through DUT
// (b = a when every enable bit is set, otherwise 0) and scores its responses.
// DUT responses arrive LAT cycles after a vector is accepted. The checker
// reports the number of vectors compared, the number of mismatches and the
// details of the first mismatch.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | out of reset; waiting for start
// S_RUN   | accepting vectors until num_vec have been taken
// S_DRAIN | all vectors taken; waiting for in-flight responses
// S_DONE  | results valid and held; start begins a new run
module or_gate_checker #(
    parameter int W   = 4,
    parameter int EW  = 3,
    parameter int LAT = 0,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] num_vec,
    input  logic          stim_valid,
    input  logic [W-1:0]  stim_a,
    input  logic [EW-1:0] stim_en,
    input  logic [W-1:0]  dut_b,
    output logic          stim_ready,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] chk_cnt,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] fe_idx,
    output logic [W-1:0]  fe_exp,
    output logic [W-1:0]  fe_got
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        r_state;
    logic          r_ready;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [CW-1:0] r_num_vec;
    logic [CW-1:0] r_acc_cnt;
    logic [CW-1:0] r_chk_cnt;
    logic [CW-1:0] r_err_cnt;
    logic [CW-1:0] r_fe_idx;
    logic [W-1:0]  r_fe_exp;
    logic [W-1:0]  r_fe_got;

    logic          w_accept;
    logic          w_last_acc;
    logic [W-1:0]  w_exp_in;
    logic          w_cmp_vld;
    logic [W-1:0]  w_cmp_exp;
    logic [CW-1:0] w_cmp_idx;
    logic          w_pipe_drained;
    logic          w_mismatch;
    logic          w_fe_load;
    logic [CW-1:0] w_chk_nxt;
    logic [CW-1:0] w_err_nxt;

    assign w_accept   = stim_valid && r_ready;
    // r_ready is only high in RUN, where num_vec is at least 1.
    assign w_last_acc = w_accept && (r_acc_cnt == r_num_vec - CW'(1));
    assign w_exp_in   = (&stim_en) ? stim_a : '0;

    generate
        if (LAT == 0) begin : g_nopipe
            assign w_cmp_vld      = w_accept;
            assign w_cmp_exp      = w_exp_in;
            assign w_cmp_idx      = r_acc_cnt;
            assign w_pipe_drained = 1'b1;
        end else begin : g_pipe
            logic [LAT-1:0] r_pv;
            logic [W-1:0]   r_pe [LAT];
            logic [CW-1:0]  r_pi [LAT];

            // Expected value and index travel alongside the DUT's own latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_pv[i] <= 1'b0;
                        r_pe[i] <= '0;
                        r_pi[i] <= '0;
                    end
                end else begin
                    r_pv[0] <= w_accept;
                    r_pe[0] <= w_exp_in;
                    r_pi[0] <= r_acc_cnt;
                    for (int i = 1; i < LAT; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pe[i] <= r_pe[i-1];
                        r_pi[i] <= r_pi[i-1];
                    end
                end
            end

            assign w_cmp_vld = r_pv[LAT-1];
            assign w_cmp_exp = r_pe[LAT-1];
            assign w_cmp_idx = r_pi[LAT-1];

            // Drained once nothing sits upstream of the stage compared this cycle,
            // so DONE lands on the edge that scores the final response.
            always_comb begin
                w_pipe_drained = 1'b1;
                for (int i = 0; i < LAT - 1; i++) begin
                    if (r_pv[i]) w_pipe_drained = 1'b0;
                end
            end
        end
    endgenerate

    assign w_mismatch = w_cmp_vld && (dut_b != w_cmp_exp);
    // err_cnt never returns to zero inside a run, so zero marks the first mismatch.
    assign w_fe_load  = w_mismatch && (r_err_cnt == '0);
    assign w_chk_nxt  = (w_cmp_vld && (r_chk_cnt != '1)) ? r_chk_cnt + CW'(1) : r_chk_cnt;
    assign w_err_nxt  = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + CW'(1) : r_err_cnt;

    // Run sequencing, scoring counters and first-error capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_num_vec <= '0;
            r_acc_cnt <= '0;
            r_chk_cnt <= '0;
            r_err_cnt <= '0;
            r_fe_idx  <= '0;
            r_fe_exp  <= '0;
            r_fe_got  <= '0;
        end else begin
            r_chk_cnt <= w_chk_nxt;
            r_err_cnt <= w_err_nxt;
            if (w_fe_load) begin
                r_fe_idx <= w_cmp_idx;
                r_fe_exp <= w_cmp_exp;
                r_fe_got <= dut_b;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_num_vec <= num_vec;
                        r_acc_cnt <= '0;
                        r_chk_cnt <= '0;
                        r_err_cnt <= '0;
                        r_fe_idx  <= '0;
                        r_fe_exp  <= '0;
                        r_fe_got  <= '0;
                        if (num_vec == '0) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_acc_cnt <= r_acc_cnt + CW'(1);
                        if (w_last_acc) begin
                            r_ready <= 1'b0;
                            if (LAT == 0) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_pass  <= (w_err_nxt == '0);
                            end else begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pipe_drained) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == '0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stim_ready = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign chk_cnt    = r_chk_cnt;
    assign err_cnt    = r_err_cnt;
    assign fe_idx     = r_fe_idx;
    assign fe_exp     = r_fe_exp;
    assign fe_got     = r_fe_got;

endmodule

// File: tb/tb_or_gate_checker.sv
// Bench for or_gate_checker: two instances (LAT=0 and LAT=2) share the
// stimulus; a reference model predicts each run's final results into
// per-instance queues, and a monitor scores them when done rises.
module tb_or_gate_checker;

    localparam int W  = 4;
    localparam int EW = 3;
    localparam int CW = 8;

    typedef struct {
        int chk;
        int err;
        int idx;
        int fexp;
        int fgot;
        int pass;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_vec = '0;
    logic          stim_valid = 1'b0;
    logic [W-1:0]  stim_a = '0;
    logic [EW-1:0] stim_en = '0;
    logic [W-1:0]  cur_got = '0;
    logic [W-1:0]  gd1 = '0;
    logic [W-1:0]  gd2 = '0;

    logic          rdy0, busy0, done0, pass0;
    logic [CW-1:0] chk0, err0, fidx0;
    logic [W-1:0]  fexp0, fgot0;
    logic          rdy2, busy2, done2, pass2;
    logic [CW-1:0] chk2, err2, fidx2;
    logic [W-1:0]  fexp2, fgot2;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q0[$];
    exp_t q2[$];
    exp_t last_exp;
    exp_t m0, m2;
    logic pd0 = 1'b0;
    logic pd2 = 1'b0;

    logic [W-1:0]  ta   [256];
    logic [EW-1:0] ten  [256];
    logic [W-1:0]  tgot [256];

    always #5 clk = ~clk;

    // Emulated DUT with two cycles of latency for the LAT=2 instance.
    always @(posedge clk) begin
        gd1 <= stim_valid ? cur_got : '0;
        gd2 <= gd1;
    end

    or_gate_checker #(.W(W), .EW(EW), .LAT(0), .CW(CW)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
        .stim_valid(stim_valid), .stim_a(stim_a), .stim_en(stim_en), .dut_b(cur_got),
        .stim_ready(rdy0), .busy(busy0), .done(done0), .pass(pass0),
        .chk_cnt(chk0), .err_cnt(err0), .fe_idx(fidx0), .fe_exp(fexp0), .fe_got(fgot0)
    );

    or_gate_checker #(.W(W), .EW(EW), .LAT(2), .CW(CW)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
        .stim_valid(stim_valid), .stim_a(stim_a), .stim_en(stim_en), .dut_b(gd2),
        .stim_ready(rdy2), .busy(busy2), .done(done2), .pass(pass2),
        .chk_cnt(chk2), .err_cnt(err2), .fe_idx(fidx2), .fe_exp(fexp2), .fe_got(fgot2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic cmp_run(input string tag, input exp_t e, input logic [CW-1:0] c,
                           input logic [CW-1:0] er, input logic [CW-1:0] ix,
                           input logic [W-1:0] fx, input logic [W-1:0] fg, input logic p);
        chk({tag, "_chk_cnt"}, 32'(c), 32'(e.chk));
        chk({tag, "_err_cnt"}, 32'(er), 32'(e.err));
        chk({tag, "_fe_idx"}, 32'(ix), 32'(e.idx));
        chk({tag, "_fe_exp"}, 32'(fx), 32'(e.fexp));
        chk({tag, "_fe_got"}, 32'(fg), 32'(e.fgot));
        chk({tag, "_pass"}, 32'(p), 32'(e.pass));
    endtask

    // Monitor: score each instance's results on the rising edge of done.
    always @(negedge clk) begin
        if (done0 && !pd0) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_lat0 done with no expected run");
            end else begin
                m0 = q0.pop_front();
                cmp_run("sb_lat0", m0, chk0, err0, fidx0, fexp0, fgot0, pass0);
            end
        end
        if (done2 && !pd2) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_lat2 done with no expected run");
            end else begin
                m2 = q2.pop_front();
                cmp_run("sb_lat2", m2, chk2, err2, fidx2, fexp2, fgot2, pass2);
            end
        end
        pd0 <= done0;
        pd2 <= done2;
    end

    // Reference: expected b is a when all enables are set, else 0.
    function automatic exp_t model(input int n);
        exp_t e;
        int   expv;
        e.chk = (n > 255) ? 255 : n;
        e.err = 0; e.idx = 0; e.fexp = 0; e.fgot = 0;
        for (int i = 0; i < n; i++) begin
            expv = (ten[i] == 3'b111) ? int'(ta[i]) : 0;
            if (int'(tgot[i]) != expv) begin
                if (e.err == 0) begin
                    e.idx = i; e.fexp = expv; e.fgot = int'(tgot[i]);
                end
                if (e.err < 255) e.err++;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_rdy0"}, 32'(rdy0), 0);   chk({tag, "_rdy2"}, 32'(rdy2), 0);
        chk({tag, "_busy0"}, 32'(busy0), 0); chk({tag, "_busy2"}, 32'(busy2), 0);
        chk({tag, "_done0"}, 32'(done0), 0); chk({tag, "_done2"}, 32'(done2), 0);
        chk({tag, "_pass0"}, 32'(pass0), 0); chk({tag, "_pass2"}, 32'(pass2), 0);
        chk({tag, "_chk0"}, 32'(chk0), 0);   chk({tag, "_chk2"}, 32'(chk2), 0);
        chk({tag, "_err0"}, 32'(err0), 0);   chk({tag, "_err2"}, 32'(err2), 0);
        chk({tag, "_fidx0"}, 32'(fidx0), 0); chk({tag, "_fidx2"}, 32'(fidx2), 0);
        chk({tag, "_fexp0"}, 32'(fexp0), 0); chk({tag, "_fexp2"}, 32'(fexp2), 0);
        chk({tag, "_fgot0"}, 32'(fgot0), 0); chk({tag, "_fgot2"}, 32'(fgot2), 0);
    endtask

    task automatic run_zero();
        exp_t e;
        e.chk = 0; e.err = 0; e.idx = 0; e.fexp = 0; e.fgot = 0; e.pass = 1;
        q0.push_back(e);
        q2.push_back(e);
        @(posedge clk) #1;
        start = 1'b1; num_vec = '0;
        @(posedge clk) #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_done0", 32'(done0), 1); chk("zero_done2", 32'(done2), 1);
        chk("zero_pass0", 32'(pass0), 1); chk("zero_pass2", 32'(pass2), 1);
        chk("zero_rdy0", 32'(rdy0), 0);   chk("zero_rdy2", 32'(rdy2), 0);
    endtask

    // gap: 0 = back-to-back, 1 = valid toggling 1,0,1,0, 2 = random.
    // abort_at >= 0 resets both instances after that many vectors are accepted.
    task automatic run(input int n, input int gap, input bit dbl_start, input int abort_at);
        exp_t e;
        int   i;
        int   cyc;
        bit   v;
        e = model(n);
        if (abort_at < 0) begin
            q0.push_back(e);
            q2.push_back(e);
            last_exp = e;
        end
        @(posedge clk) #1;
        start = 1'b1; num_vec = CW'(n);
        @(posedge clk) #1;
        start = 1'b0;
        i = 0; cyc = 0;
        while (i < n && cyc < 500) begin
            if (i == abort_at) break;
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            stim_valid = v;
            if (v) begin
                stim_a = ta[i]; stim_en = ten[i]; cur_got = tgot[i];
            end else begin
                stim_a = 4'($urandom_range(0, 15)); cur_got = 4'($urandom_range(0, 15));
            end
            if (dbl_start && cyc == 3) begin
                start = 1'b1; num_vec = CW'(n + 5);
            end
            @(negedge clk);
            chk("run_rdy0", 32'(rdy0), 1);
            chk("run_rdy2", 32'(rdy2), 1);
            @(posedge clk) #1;
            start = 1'b0; num_vec = CW'(n);
            if (v) i++;
            cyc++;
        end
        stim_valid = 1'b0;
        cur_got = 4'($urandom_range(0, 15));
        if (abort_at >= 0) begin
            rst_n = 1'b0;
            #1;
            check_zero("abort");
            @(negedge clk);
            @(negedge clk);
            check_zero("abort_hold");
            rst_n = 1'b1;
        end else begin
            if (i < n) begin
                n_checks++;
                n_errors++;
                $display("FAIL run_timeout got %0d vectors expected %0d", i, n);
            end
            @(negedge clk);
            chk("end_done0", 32'(done0), 1); chk("end_done2_e1", 32'(done2), 0);
            chk("end_rdy0", 32'(rdy0), 0);   chk("end_rdy2", 32'(rdy2), 0);
            chk("end_busy0", 32'(busy0), 0); chk("end_busy2_e1", 32'(busy2), 1);
            @(negedge clk);
            chk("end_done2_e2", 32'(done2), 0);
            @(negedge clk);
            chk("end_done2_e3", 32'(done2), 1); chk("end_busy2_e3", 32'(busy2), 0);
        end
    endtask

    // Valid presented while the checker is finished must not be scored.
    task automatic post_ignored();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk) #1;
            stim_valid = 1'b1; stim_en = 3'b111;
            stim_a = 4'($urandom_range(0, 15)); cur_got = ~stim_a;
            @(negedge clk);
            chk("ign_rdy0", 32'(rdy0), 0);
            chk("ign_chk0", 32'(chk0), 32'(last_exp.chk));
            chk("ign_err0", 32'(err0), 32'(last_exp.err));
            chk("ign_chk2", 32'(chk2), 32'(last_exp.chk));
        end
        @(posedge clk) #1;
        stim_valid = 1'b0;
    endtask

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_zero();

        for (int k = 0; k < 4; k++) begin
            ta[k] = 4'(k); ten[k] = 3'b111; tgot[k] = 4'(k);
        end
        run(4, 0, 1'b0, -1);
        post_ignored();

        for (int k = 0; k < 4; k++) begin
            ta[k] = 4'h1; ten[k] = 3'b011; tgot[k] = 4'h1;
        end
        run(4, 0, 1'b0, -1);

        for (int k = 0; k < 3; k++) begin
            ta[k] = 4'($urandom_range(0, 15)); ten[k] = 3'b111; tgot[k] = ta[k];
        end
        run(3, 0, 1'b0, -1);

        for (int k = 0; k < 6; k++) begin
            ta[k] = 4'($urandom_range(0, 15)); ten[k] = 3'b111; tgot[k] = ta[k];
        end
        run(6, 1, 1'b1, -1);

        for (int k = 0; k < 4; k++) begin
            ta[k] = 4'($urandom_range(0, 15)); ten[k] = 3'b111; tgot[k] = 4'($urandom_range(0, 15));
        end
        run(4, 0, 1'b0, 2);
        ta[0] = 4'h9; ten[0] = 3'b111; tgot[0] = 4'h9;
        run(1, 0, 1'b0, -1);

        for (int r = 0; r < 8; r++) begin
            int n;
            n = (r == 7) ? 40 : int'($urandom_range(1, 12));
            for (int k = 0; k < n; k++) begin
                ta[k]  = 4'($urandom_range(0, 15));
                ten[k] = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
                if ($urandom_range(0, 4) == 0) tgot[k] = 4'($urandom_range(0, 15));
                else tgot[k] = (ten[k] == 3'b111) ? ta[k] : 4'h0;
            end
            run(n, r % 3, 1'b0, -1);
        end
        post_ignored();

        repeat (4) @(negedge clk);
        chk("sb_lat0_left", 32'(q0.size()), 0);
        chk("sb_lat2_left", 32'(q2.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
